// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle, plus the register-file rs1 read select.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_class;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [4:0]  reg1_select;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_funct3, out_funct7b5,
           out_rd, out_rs2, out_imm, out_illegal, reg1_select
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_funct3, out_funct7b5,
           out_rd, out_rs2, out_imm, out_illegal, reg1_select
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decoder with one skid entry, feeding the register file's synchronous rs1 read.
// Optional DECODE_RV32E_EN: restrict register indices to x0-x15.
module decode_stage #(
  parameter bit ILLEGAL_ZERO_RD = 1'b1,
  parameter int SKID_DEPTH      = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  decode_stage_if.slave bus
);

  if (SKID_DEPTH != 1) begin : g_bad_skid_depth
    $error("decode_stage: only SKID_DEPTH=1 is supported");
  end

  typedef enum logic [3:0] {
    C_ILL = 4'd0, C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3, C_JALR = 4'd4,
    C_BRANCH = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7, C_OP_IMM = 4'd8,
    C_OP = 4'd9, C_FENCE = 4'd10, C_SYSTEM = 4'd11
  } cls_e;

  typedef struct packed {
    logic [31:0] pc;
    cls_e        cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t        d;
    logic        legal;
    logic [6:0]  f7;
    logic [2:0]  f3;
    cls_e        cls;
    logic [31:0] imm;
`ifdef DECODE_RV32E_EN
    logic        hi;
`endif
    d     = '0;
    f7    = ins[31:25];
    f3    = ins[14:12];
    legal = 1'b1;
    cls   = C_ILL;
    imm   = '0;
    if (ins[1:0] != 2'b11) legal = 1'b0;
    else begin
      case (ins[6:2])
        5'b01101: begin cls = C_LUI;    imm = {ins[31:12], 12'b0}; end
        5'b00101: begin cls = C_AUIPC;  imm = {ins[31:12], 12'b0}; end
        5'b11011: begin
          cls = C_JAL;
          imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        5'b11001: begin cls = C_JALR;   imm = {{20{ins[31]}}, ins[31:20]}; legal = (f3 == 3'd0); end
        5'b11000: begin
          cls   = C_BRANCH;
          imm   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
          legal = (f3 != 3'd2) && (f3 != 3'd3);
        end
        5'b00000: begin
          cls   = C_LOAD;
          imm   = {{20{ins[31]}}, ins[31:20]};
          legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        end
        5'b01000: begin
          cls   = C_STORE;
          imm   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
          legal = (f3 < 3'd3);
        end
        5'b00100: begin
          cls = C_OP_IMM;
          imm = {{20{ins[31]}}, ins[31:20]};
          if (f3 == 3'd1)      legal = (f7 == 7'h00);
          else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        end
        5'b01100: begin
          cls   = C_OP;
          // SUB and SRA are the only alternate encodings in the base ISA
          legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        end
        5'b00011: begin cls = C_FENCE;  imm = {{20{ins[31]}}, ins[31:20]}; legal = (f3 == 3'd0); end
        5'b11100: begin
          cls = C_SYSTEM;
          imm = {{20{ins[31]}}, ins[31:20]};
          if (f3 == 3'd0) legal = (ins[31:7] == 25'h0) || (ins[31:7] == 25'h0002000);
          else            legal = (f3 != 3'd4);
        end
        default: legal = 1'b0;
      endcase
    end
`ifdef DECODE_RV32E_EN
    case (cls)
      C_LUI, C_AUIPC, C_JAL:              hi = ins[11];
      C_JALR, C_LOAD, C_OP_IMM, C_SYSTEM: hi = ins[11] | ins[19];
      C_BRANCH, C_STORE:                  hi = ins[19] | ins[24];
      C_OP:                               hi = ins[11] | ins[19] | ins[24];
      default:                            hi = 1'b0;
    endcase
    if (hi) legal = 1'b0;
`endif
    d.pc   = pc;
    d.f3   = f3;
    d.f7b5 = ins[30];
    d.rs2  = ins[24:20];
    d.rd   = (cls == C_BRANCH || cls == C_STORE || cls == C_FENCE) ? 5'd0 : ins[11:7];
    d.rs1  = (cls == C_LUI || cls == C_AUIPC || cls == C_JAL) ? 5'd0 : ins[19:15];
    if (!legal) begin
      cls  = C_ILL;
      imm  = '0;
      d.rd = ILLEGAL_ZERO_RD ? 5'd0 : ins[11:7];
      d.rs1 = ins[19:15];
    end
`ifdef DECODE_RV32E_EN
    d.rs1[4] = 1'b0;
`endif
    d.cls = cls;
    d.imm = imm;
    d.ill = !legal;
    return d;
  endfunction

  dec_t        or_q, or_d, src;
  logic        or_vld_q, or_vld_d;
  logic [31:0] sk_instr_q, sk_instr_d, sk_pc_q, sk_pc_d;
  logic        sk_vld_q, sk_vld_d;
  logic        rdy_q, rdy_d;
  logic        accept, adv;

  // The skid entry always drains first, so a single decoder on the OR source is enough.
  always_comb begin
    accept     = bus.in_valid && rdy_q;
    adv        = !or_vld_q || bus.out_ready;
    src        = sk_vld_q ? decode(sk_instr_q, sk_pc_q) : decode(bus.in_instr, bus.in_pc);
    or_d       = or_q;
    or_vld_d   = or_vld_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;
    sk_vld_d   = sk_vld_q;
    if (adv) begin
      if (sk_vld_q || accept) begin
        or_d     = src;
        or_vld_d = 1'b1;
      end else begin
        or_vld_d = 1'b0;
      end
    end
    if (accept && (!adv || sk_vld_q)) begin
      sk_instr_d = bus.in_instr;
      sk_pc_d    = bus.in_pc;
      sk_vld_d   = 1'b1;
    end else if (adv && sk_vld_q) begin
      sk_vld_d = 1'b0;
    end
    if (flush) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end
    rdy_d = !sk_vld_d;
    // Select the rs1 of whatever OR will hold next cycle so read data lines up with OR.
    bus.reg1_select = (adv && (sk_vld_q || accept)) ? src.rs1 : or_q.rs1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      or_q       <= '0;
      or_vld_q   <= 1'b0;
      sk_instr_q <= '0;
      sk_pc_q    <= '0;
      sk_vld_q   <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      or_q       <= or_d;
      or_vld_q   <= or_vld_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
      sk_vld_q   <= sk_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.in_ready     = rdy_q;
  assign bus.out_valid    = or_vld_q;
  assign bus.out_pc       = or_q.pc;
  assign bus.out_class    = or_q.cls;
  assign bus.out_funct3   = or_q.f3;
  assign bus.out_funct7b5 = or_q.f7b5;
  assign bus.out_rd       = or_q.rd;
  assign bus.out_rs2      = or_q.rs2;
  assign bus.out_imm      = or_q.imm;
  assign bus.out_illegal  = or_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode fields, streaming, stall/skid, illegal, flush.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset, flush;
  int   checks = 0;
  int   failures = 0;

  decode_stage_if bus ();

  decode_stage dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction with out_ready high; it sits in OR after the edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  logic [31:0] s_ins [4] = '{32'h123452B7, 32'h002081B3, 32'h40118233, 32'h00208463};
  logic [3:0]  s_cls [4] = '{4'd1, 4'd9, 4'd9, 4'd5};
  logic [4:0]  s_rd  [4] = '{5'd5, 5'd3, 5'd4, 5'd0};
  logic [4:0]  s_rs1 [4] = '{5'd0, 5'd1, 5'd3, 5'd1};
  logic [31:0] s_imm [4] = '{32'h12345000, 32'h0, 32'h0, 32'h8};
  logic        s_f7  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_reg1", bus.reg1_select, 0);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_pc", bus.out_pc, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);

    // addi x1,x0,5
    bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
    #1;
    chk("addi_reg1_accept", bus.reg1_select, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_class", bus.out_class, 8);
    chk("addi_rd", bus.out_rd, 1);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_ill", bus.out_illegal, 0);

    // back-to-back stream: lui, add, sub, beq
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.in_instr = s_ins[k]; bus.in_pc = 32'h200 + 32'(4 * k);
      #1;
      chk("strm_reg1", bus.reg1_select, s_rs1[k]);
      chk("strm_in_ready", bus.in_ready, 1);
      tick();
      chk("strm_valid", bus.out_valid, 1);
      chk("strm_class", bus.out_class, s_cls[k]);
      chk("strm_rd", bus.out_rd, s_rd[k]);
      chk("strm_imm", bus.out_imm, s_imm[k]);
      chk("strm_f7b5", bus.out_funct7b5, s_f7[k]);
      chk("strm_pc", bus.out_pc, 32'h200 + 32'(4 * k));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("strm_drain", bus.out_valid, 0);

    // stall: X=addi x2,x1,3 in OR, Y=sub x4,x3,x1 into skid, Z=lui waits
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00308113; bus.in_pc = 32'h300;
    tick();
    chk("stall_x_valid", bus.out_valid, 1);
    bus.in_instr = 32'h40118233; bus.in_pc = 32'h304;
    #1;
    chk("stall_reg1_or", bus.reg1_select, 1);
    chk("stall_in_ready_pre", bus.in_ready, 1);
    tick();
    chk("stall_in_ready_sk", bus.in_ready, 0);
    chk("stall_pc_held", bus.out_pc, 32'h300);
    chk("stall_reg1_held", bus.reg1_select, 1);
    bus.in_instr = 32'h123452B7; bus.in_pc = 32'h308;
    tick();
    chk("stall3_in_ready", bus.in_ready, 0);
    chk("stall3_pc", bus.out_pc, 32'h300);
    chk("stall3_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("release_reg1_sk", bus.reg1_select, 3);
    tick();
    chk("release_y_pc", bus.out_pc, 32'h304);
    chk("release_y_class", bus.out_class, 9);
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_reg1_in", bus.reg1_select, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("release_z_pc", bus.out_pc, 32'h308);
    chk("release_z_class", bus.out_class, 1);
    chk("release_z_imm", bus.out_imm, 32'h12345000);

    // sw x2,-4(x1)
    issue(32'hFE20AE23, 32'h400);
    chk("sw_class", bus.out_class, 7);
    chk("sw_rd", bus.out_rd, 0);
    chk("sw_rs2", bus.out_rs2, 2);
    chk("sw_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("sw_f3", bus.out_funct3, 2);
    issue(32'h8000006F, 32'h404);
    chk("jal_class", bus.out_class, 3);
    chk("jal_imm_neg", bus.out_imm, 32'hFFF00000);
    issue(32'h0000006F, 32'h408);
    chk("jal_imm_zero", bus.out_imm, 0);

    // illegal encodings and an ECALL boundary
    issue(32'h00000000, 32'h500);
    chk("zero_ill", bus.out_illegal, 1);
    chk("zero_class", bus.out_class, 0);
    chk("zero_rd", bus.out_rd, 0);
    issue(32'h40001033, 32'h504);
    chk("sll_f7_ill", bus.out_illegal, 1);
    chk("sll_f7_class", bus.out_class, 0);
    issue(32'h400010B3, 32'h508);
    chk("sll_f7_rd1_ill", bus.out_illegal, 1);
    chk("sll_f7_rd_zero", bus.out_rd, 0);
    issue(32'h00000073, 32'h50C);
    chk("ecall_class", bus.out_class, 11);
    chk("ecall_ill", bus.out_illegal, 0);
    tick();

    // flush with OR and skid both full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00308113; bus.in_pc = 32'h600;
    tick();
    bus.in_instr = 32'h40118233; bus.in_pc = 32'h604;
    tick();
    chk("fl_pre_in_ready", bus.in_ready, 0);
    chk("fl_pre_valid", bus.out_valid, 1);
    flush = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h608;
    tick();
    flush = 1'b0;
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("fl_skid_gone", bus.out_valid, 0);
    // an instruction offered while flushing is dropped
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h00500093;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl_drop_offer", bus.out_valid, 0);

    // x17 destination
    issue(32'h00100893, 32'h700);
`ifdef DECODE_RV32E_EN
    chk("x17_ill", bus.out_illegal, 1);
    chk("x17_class", bus.out_class, 0);
`else
    chk("x17_ill", bus.out_illegal, 0);
    chk("x17_rd", bus.out_rd, 17);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
